// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, totals and address width shared by scanout, frame buffer and drawing
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  function automatic int addr_width(input int h, input int v);
    return $clog2(h * v);
  endfunction
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction
  localparam int DEF_ADDR_WIDTH = addr_width(DEF_H_ACTIVE, DEF_V_ACTIVE);
endpackage

// File: rtl/vga_scanout_if.sv
// vga_scanout_if: frame buffer read port; address out, pixel back one clock later
interface vga_scanout_if import vga_pkg::*; #(parameter int ADDR_WIDTH = DEF_ADDR_WIDTH);
  logic [ADDR_WIDTH-1:0] read_addr;
  logic read_data;
  modport master (output read_addr, input read_data);
  modport slave (input read_addr, output read_data);
endinterface

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: raster position counters with active flag and line/frame wrap strobes
module vga_timing_counter import vga_pkg::*; #(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int HW = cnt_width(H_TOTAL),
  parameter int VW = cnt_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          line_end,
  output logic          frame_end
);
  assign line_end = h_cnt == HW'(H_TOTAL - 1);
  assign frame_end = line_end && v_cnt == VW'(V_TOTAL - 1);
  assign active = h_cnt < HW'(H_ACTIVE) && v_cnt < VW'(V_ACTIVE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= line_end ? '0 : h_cnt + 1'b1;
      v_cnt <= frame_end ? '0 : line_end ? v_cnt + 1'b1 : v_cnt;
    end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing + front-buffer scanout with once-per-frame swap; VGA_SCANOUT_TEST_PATTERN_EN adds a checkerboard input
module vga_scanout import vga_pkg::*; #(
  parameter int HOR_ACTIVE_PIXELS = DEF_H_ACTIVE,
  parameter int HOR_FRONT_PORCH = DEF_H_FP,
  parameter int HOR_SYNC = DEF_H_SYNC,
  parameter int HOR_BACK_PORCH = DEF_H_BP,
  parameter int VER_ACTIVE_PIXELS = DEF_V_ACTIVE,
  parameter int VER_FRONT_PORCH = DEF_V_FP,
  parameter int VER_SYNC = DEF_V_SYNC,
  parameter int VER_BACK_PORCH = DEF_V_BP,
  parameter int SYNC_ACTIVE = 0
) (
  input  logic clk,
  input  logic rst_n,
  vga_scanout_if.master fb,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  input  logic test_pattern,
`endif
  output logic swap,
  output logic hsync,
  output logic vsync,
  output logic de,
  output logic pixel
);
  localparam int H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
  localparam int V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;
  localparam int HW = cnt_width(H_TOTAL);
  localparam int VW = cnt_width(V_TOTAL);
  localparam int ADDR_WIDTH = addr_width(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS);
  localparam int HS_START = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH;
  localparam int VS_START = VER_ACTIVE_PIXELS + VER_FRONT_PORCH;
  localparam logic SYNC_LVL = 1'(SYNC_ACTIVE);
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic active, line_end, frame_end;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  vga_timing_counter #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .H_ACTIVE(HOR_ACTIVE_PIXELS), .V_ACTIVE(VER_ACTIVE_PIXELS),
    .HW(HW), .VW(VW)
  ) u_tc (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .active(active), .line_end(line_end), .frame_end(frame_end)
  );
  assign fb.read_addr = addr_cnt;
  // swap is registered one clock early so it is high exactly while the raster sits at (0, VER_ACTIVE_PIXELS)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_cnt <= '0;
      hsync <= ~SYNC_LVL;
      vsync <= ~SYNC_LVL;
      de <= 1'b0;
      swap <= 1'b0;
    end else begin
      addr_cnt <= frame_end ? '0 : active ? addr_cnt + 1'b1 : addr_cnt;
      hsync <= (h_cnt >= HW'(HS_START) && h_cnt < HW'(HS_START + HOR_SYNC)) ? SYNC_LVL : ~SYNC_LVL;
      vsync <= (v_cnt >= VW'(VS_START) && v_cnt < VW'(VS_START + VER_SYNC)) ? SYNC_LVL : ~SYNC_LVL;
      de <= active;
      swap <= line_end && v_cnt == VW'(VER_ACTIVE_PIXELS - 1);
    end
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  logic tp_bit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tp_bit <= 1'b0;
    else tp_bit <= h_cnt[3] ^ v_cnt[3];
  assign pixel = de & (test_pattern ? tp_bit : fb.read_data);
`else
  assign pixel = de & fb.read_data;
`endif
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of sync/de/pixel timing, address sequencing, swap and mid-frame reset on a reduced raster
module tb_vga_scanout;
  import vga_pkg::*;
  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 12, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int AW = addr_width(HA, VA);
  logic clk = 0, rst_n = 0;
  logic swap, hsync, vsync, de, pixel;
  int fb_mode = 0;
  int checks = 0, failures = 0;
  int edge_n = 0;
  int hs_err, vs_err, de_err, px_err, de_cnt, hs_lo, vs_lo, px_ones;
  int swaps[$];
  logic line0[16];
  logic [31:0] ra_last, ra_wrap;
  logic tp_px[3];
  vga_scanout_if #(.ADDR_WIDTH(AW)) fb_if();
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  logic test_pattern = 0;
`endif
  vga_scanout #(
    .HOR_ACTIVE_PIXELS(HA), .HOR_FRONT_PORCH(HFP), .HOR_SYNC(HS), .HOR_BACK_PORCH(HBP),
    .VER_ACTIVE_PIXELS(VA), .VER_FRONT_PORCH(VFP), .VER_SYNC(VS), .VER_BACK_PORCH(VBP),
    .SYNC_ACTIVE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fb(fb_if),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .swap(swap), .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk)
    fb_if.read_data <= fb_mode == 1 ? 1'b1 : fb_mode == 2 ? 1'b0 : fb_if.read_addr[0];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clear();
    {hs_err, vs_err, de_err, px_err, de_cnt, hs_lo, vs_lo, px_ones} = '0;
    swaps.delete();
  endtask
  task automatic check_reset(input string ph);
    check({ph, "_hsync"}, hsync, 1);
    check({ph, "_vsync"}, vsync, 1);
    check({ph, "_de"}, de, 0);
    check({ph, "_pixel"}, pixel, 0);
    check({ph, "_swap"}, swap, 0);
    check({ph, "_read_addr"}, fb_if.read_addr, 0);
  endtask
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1;
    edge_n = 0;
    clear();
  endtask
  task automatic run(input int n);
    int p, x, y;
    logic xde, xpx;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_n++;
      p = (edge_n - 1) % FRAME;
      x = p % HT;
      y = p / HT;
      xde = x < HA && y < VA;
      xpx = xde & (fb_mode == 1 ? 1'b1 : fb_mode == 2 ? 1'b0 : x[0]);
      if (hsync !== !(x >= HA + HFP && x < HA + HFP + HS)) hs_err++;
      if (vsync !== !(y >= VA + VFP && y < VA + VFP + VS)) vs_err++;
      if (de !== xde) de_err++;
      if (pixel !== xpx) px_err++;
      if (de) de_cnt++;
      if (!hsync) hs_lo++;
      if (!vsync) vs_lo++;
      if (pixel) px_ones++;
      if (swap) swaps.push_back(edge_n);
      if (edge_n <= 16) line0[edge_n-1] = pixel;
      if (edge_n == (VA - 1) * HT + HA - 1) ra_last = 32'(fb_if.read_addr);
      if (edge_n == FRAME) ra_wrap = 32'(fb_if.read_addr);
      if (edge_n == 9) tp_px[0] = pixel;
      if (edge_n == 8 * HT + 1) tp_px[1] = pixel;
      if (edge_n == 8 * HT + 9) tp_px[2] = pixel;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    release_reset();
    #1;
    check("first_read_addr", fb_if.read_addr, 0);
    run(3 * FRAME);
    for (int i = 0; i < 16; i++) check($sformatf("line0_px%0d", i), line0[i], i % 2);
    check("last_addr", ra_last, HA * VA - 1);
    check("wrap_addr", ra_wrap, 0);
    check("hs_pattern_err", hs_err, 0);
    check("vs_pattern_err", vs_err, 0);
    check("de_pattern_err", de_err, 0);
    check("px_pattern_err", px_err, 0);
    check("de_clocks", de_cnt, 3 * HA * VA);
    check("hsync_low_clocks", hs_lo, 3 * VT * HS);
    check("vsync_low_clocks", vs_lo, 3 * VS * HT);
    check("swap_count", swaps.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("swap_edge%0d", i), i < swaps.size() ? swaps[i] : -1, HT * VA + i * FRAME);
    run(4 * HT + 6);
    check("pre_rst_de", de, 1);
    check("pre_rst_pixel", pixel, 1);
    check("pre_rst_addr", fb_if.read_addr, 4 * HA + 6);
    rst_n = 0;
    #1;
    check_reset("mid_rst");
    repeat (5) @(posedge clk);
    fb_mode = 1;
    release_reset();
    run(FRAME);
    check("ones_de_err", de_err, 0);
    check("ones_px_err", px_err, 0);
    check("ones_px_count", px_ones, HA * VA);
    check("rst_swap_count", swaps.size(), 1);
    check("rst_swap_edge", swaps.size() > 0 ? swaps[0] : -1, HT * VA);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    rst_n = 0;
    fb_mode = 2;
    test_pattern = 1;
    repeat (2) @(posedge clk);
    release_reset();
    run(8 * HT + 10);
    check("tp_8_0", tp_px[0], 1);
    check("tp_0_8", tp_px[1], 1);
    check("tp_8_8", tp_px[2], 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
